pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM driver.
- Measures the high time of STAGE PWM channels over one PWM period of 2^DWIDTH clocks, started by a frame sync pulse.
- Reconstructs each channel's DWIDTH-bit data word and streams the words out serially, channel 0 first, over a valid/ready handshake.
- Used for loopback verification of the driver and for monitoring PWM outputs on the board.

Parameters:
- DWIDTH, 8, data word width; one PWM period = 2^DWIDTH clock cycles.
- STAGE, 8, number of PWM input channels.

Ports:
- clk  input  1  single clock; all inputs are synchronous to it.
- rst  input  1  synchronous, active-high reset.
- frame_sync  input  1  one-cycle pulse that starts a measurement window.
- pwm_in  input  STAGE  PWM channel levels; bit i is channel i.
- out_data  output  DWIDTH  measured word for the current channel.
- out_chan  output  $clog2(STAGE)  channel index of out_data.
- out_valid  output  1  out_data and out_chan are valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- frame_done  output  1  one-cycle pulse after the last channel is accepted.
- overrun  output  1  sticky flag: a completed frame was dropped because the previous frame had not drained.
- sat  output  STAGE  sticky per-channel flag: channel was high for all 2^DWIDTH cycles.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, out_data=0, out_chan=0, frame_done=0, overrun=0, sat=0.
  - Window counter, accumulators and buffer cleared; measurement FSM goes to IDLE, drain FSM goes to EMPTY.
  - Reset mid-window or mid-drain discards everything; there is no partial output.
- Measurement FSM (IDLE, MEASURE):
  - IDLE: frame_sync=1 -> MEASURE; window count wcnt=0; all accumulators cleared.
  - MEASURE, every cycle: accumulator i += pwm_in[i]; wcnt += 1.
  - The cycle when frame_sync is sampled is not itself measured. The first measured cycle is the next one, and the window is exactly 2^DWIDTH cycles.
  - Accumulators are DWIDTH+1 bits wide. The result is min(acc, 2^DWIDTH-1). If acc reaches 2^DWIDTH, set sat[i]; it is sticky until rst.
  - MEASURE with wcnt = 2^DWIDTH-1: this is the last sample. Next state IDLE. At this clock edge the results, including the last sample, are handed to the drain FSM.
  - frame_sync=1 during MEASURE: abort the window, clear the accumulators, set wcnt=0, stay in MEASURE. This restart does not set overrun.
  - frame_sync=1 on the last MEASURE cycle: the frame completes and is handed off, and a new window starts on the next cycle.
- Drain FSM (EMPTY, SEND):
  - Hand-off while EMPTY: all STAGE saturated results load into the buffer; state -> SEND; out_chan=0; out_valid=1 from the following cycle.
  - Hand-off while SEND: the new results are dropped, overrun is set (sticky until rst), and the current drain continues undisturbed.
  - SEND: out_data = buffer[out_chan].
  - out_valid && out_ready: out_chan advances one step. On acceptance of channel STAGE-1, out_valid=0, the state goes to EMPTY, and frame_done pulses high for exactly one cycle.
  - A hand-off in that same cycle counts as arriving while SEND, so it sets overrun.
  - out_data and out_chan stay stable while out_valid && !out_ready.
  - Throughput: one word per cycle when out_ready is held high. Minimum drain time is STAGE cycles, which is much shorter than one window.
- Latency: out_valid for channel 0 rises 2^DWIDTH+1 cycles after the frame_sync cycle.
- Expected encoding: a driver that outputs high while count < data produces high time = data, so the captured word equals the driven word for 0..2^DWIDTH-1.

Decomposition:
- Shared package pwm_pkg:
  - localparam PERIOD = 2**DWIDTH.
  - typedef enum for the measurement FSM states (IDLE, MEASURE).
  - typedef enum for the drain FSM states (EMPTY, SEND).
  - Channel-index width function.
- Sub-module pwm_meas_chan (one per channel, generate loop):
  - Contains the accumulator and the saturation flag.
  - Inputs: clk, rst, clear, en, pwm bit.
  - Outputs: saturated DWIDTH-bit result and the sat pulse.
- The top level holds the window counter, both FSMs, the buffer and the handshake.

Test Plan:
- Basic capture: rst, then frame_sync. Channel i is held high for exactly 10*i+3 cycles of the window; out_ready=1. Required: 8 words in order, chan 0..7, data 3, 13, ..., 73; out_valid rises 257 cycles after frame_sync; frame_done pulses once after chan 7.
- Boundaries: channel 0 never high, channel 1 high 255 cycles, channel 2 high all 256 cycles. Required: data 0, 255, 255; sat = 8'b0000_0100; sat[1]=0.
- Backpressure: out_ready toggled randomly with 25% duty. Required: out_data and out_chan stable while stalled, no word lost or duplicated, frame_done only after the chan 7 handshake.
- Overrun: out_ready=0 through a second complete window. Required: overrun=1; after out_ready=1, the first frame's 8 words are delivered unchanged; the second frame is never output.
- Restart and reset: frame_sync re-pulsed at window cycle 100 with channel 0 high throughout. Required: output 255, not 255+100, and overrun=0. Separately, rst mid-drain at chan 3: out_valid=0 the next cycle and all flags clear.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM capture block.
//   PERIOD      : clocks per PWM window at the default data width
//   meas_state_e: measurement FSM states
//   drain_state_e: output drain FSM states
//   chan_w()    : channel-index width, never narrower than one bit
package pwm_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int PERIOD     = 2**DEF_DWIDTH;

  typedef enum logic {M_IDLE, M_MEASURE} meas_state_e;
  typedef enum logic {D_EMPTY, D_SEND}   drain_state_e;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_meas_chan.sv
// One PWM channel's high-time accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : zero the accumulator (new window)
//   en_i     : window is open, count this cycle's sample
//   pwm_i    : channel level
//   result_o : saturated count including the current sample
//   sat_o    : current sample brings the count to a full period
module pwm_meas_chan #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              pwm_i,
  output logic [DWIDTH-1:0] result_o,
  output logic              sat_o
);

  logic [DWIDTH:0] acc_q, acc_d;

  // Result is taken from the next-state value so the hand-off edge
  // includes the final sample of the window.
  always_comb acc_d = acc_q + {{DWIDTH{1'b0}}, en_i & pwm_i};

  assign result_o = acc_d[DWIDTH] ? {DWIDTH{1'b1}} : acc_d[DWIDTH-1:0];
  assign sat_o    = en_i & acc_d[DWIDTH];

  always_ff @(posedge clk) begin
    if (rst)          acc_q <= '0;
    else if (clear_i) acc_q <= '0;
    else              acc_q <= acc_d;
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures STAGE channels' high time over a 2^DWIDTH-clock
// window opened by frame_sync, then streams the words out channel 0 first.
//   clk, rst   : clock, synchronous active-high reset
//   frame_sync : starts (or restarts) a measurement window
//   pwm_in     : channel levels
//   out_data/out_chan/out_valid/out_ready : word stream handshake
//   frame_done : pulse after the last channel is accepted
//   overrun    : sticky, a finished frame was dropped during a drain
//   sat        : sticky per channel, channel high for the whole window
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int STAGE  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_sync,
  input  logic [STAGE-1:0]          pwm_in,
  output logic [DWIDTH-1:0]         out_data,
  output logic [chan_w(STAGE)-1:0]  out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic                      overrun,
  output logic [STAGE-1:0]          sat
);

  localparam int CW = chan_w(STAGE);

  meas_state_e              mst_q;
  logic [DWIDTH-1:0]        wcnt_q;
  logic                     meas_en, last, handoff;
  logic [STAGE-1:0][DWIDTH-1:0] res;
  logic [STAGE-1:0]         sat_p;

  drain_state_e             dst_q;
  logic [STAGE-1:0][DWIDTH-1:0] buf_q;
  logic [CW-1:0]            chan_q;
  logic                     valid_q, done_q, ovr_q;
  logic [STAGE-1:0]         sat_q;

  assign meas_en = (mst_q == M_MEASURE);
  assign last    = meas_en && (wcnt_q == {DWIDTH{1'b1}});
  assign handoff = last;

  for (genvar gi = 0; gi < STAGE; gi++) begin : g_chan
    pwm_meas_chan #(.DWIDTH(DWIDTH)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (frame_sync),
      .en_i     (meas_en),
      .pwm_i    (pwm_in[gi]),
      .result_o (res[gi]),
      .sat_o    (sat_p[gi])
    );
  end

  // Measurement FSM. frame_sync always wins: it (re)opens the window even
  // on the last cycle, where the completed frame is still handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_q  <= M_IDLE;
      wcnt_q <= '0;
    end else begin
      case (mst_q)
        M_IDLE: begin
          if (frame_sync) begin
            mst_q  <= M_MEASURE;
            wcnt_q <= '0;
          end
        end
        M_MEASURE: begin
          if (frame_sync) begin
            wcnt_q <= '0;
          end else if (last) begin
            mst_q  <= M_IDLE;
            wcnt_q <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: mst_q <= M_IDLE;
      endcase
    end
  end

  // Drain FSM. A hand-off arriving while a frame is still draining (even on
  // its final acceptance cycle) is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q   <= D_EMPTY;
      buf_q   <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      sat_q  <= sat_q | sat_p;
      case (dst_q)
        D_EMPTY: begin
          if (handoff) begin
            buf_q   <= res;
            chan_q  <= '0;
            valid_q <= 1'b1;
            dst_q   <= D_SEND;
          end
        end
        D_SEND: begin
          if (handoff) ovr_q <= 1'b1;
          if (valid_q && out_ready) begin
            if (chan_q == CW'(STAGE-1)) begin
              chan_q  <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              dst_q   <= D_EMPTY;
            end else begin
              chan_q <= chan_q + 1'b1;
            end
          end
        end
        default: dst_q <= D_EMPTY;
      endcase
    end
  end

  assign out_data   = valid_q ? buf_q[chan_q] : '0;
  assign out_chan   = chan_q;
  assign out_valid  = valid_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign sat        = sat_q;

endmodule
